// File: rtl/gf180mcu_osu_sc_drv_pkg.sv
// Shared types and helpers for the staged driver-enable sequencer.
// Used by the sequencer top and its step timer.
package gf180mcu_osu_sc_drv_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD      = 2'd3
    } drv_state_e;

    // One bit of a thermometer code: bit idx is set when level exceeds idx.
    function automatic logic therm_bit(int lvl, int idx);
        return idx < lvl;
    endfunction

    function automatic int clamp(int v, int hi);
        return (v > hi) ? hi : v;
    endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_gp12t3v3__drv_step_timer.sv
// Loadable down-counter with zero flag; spaces driver stage changes.
// Holds at zero when not reloaded.
module gf180mcu_osu_sc_gp12t3v3__drv_step_timer
    import gf180mcu_osu_sc_drv_pkg::*;
#(
    parameter int STEP_CYCLES = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int CW = $clog2(STEP_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/gf180mcu_osu_sc_gp12t3v3__drv_stage_ctrl.sv
// Staged enable sequencer for parallel buf_8 driver segments.
// GF180MCU_OSU_DRV_SOFTOFF_EN: stage ramp-down like ramp-up.
module gf180mcu_osu_sc_gp12t3v3__drv_stage_ctrl
    import gf180mcu_osu_sc_drv_pkg::*;
#(
    parameter int N_STAGES    = 4,
    parameter int STEP_CYCLES = 8,
    parameter int TW          = $clog2(N_STAGES + 1)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REQ,
    input  logic [TW-1:0]       TGT,
    output logic [N_STAGES-1:0] STAGE_EN,
    output logic                ACK,
    output logic                BUSY
);

    drv_state_e    r_state;
    logic [TW-1:0] r_lvl;
    logic [TW-1:0] r_tgt;
    logic          r_ack;
    logic          r_busy;

    logic [TW-1:0] w_tgt_eff;
    logic          w_stable;
    logic          w_zero;
    logic          w_load;
    logic          w_dec;

    assign w_tgt_eff = REQ ? TW'(clamp(32'(TGT), N_STAGES)) : '0;
    assign w_stable  = (r_state == IDLE) || (r_state == HOLD);
    assign w_load    = w_stable ? (w_tgt_eff != r_lvl)
                                : (w_zero && r_lvl != r_tgt);
    assign w_dec     = !w_stable;

    gf180mcu_osu_sc_gp12t3v3__drv_step_timer #(
        .STEP_CYCLES(STEP_CYCLES)
    ) u_timer (
        .CLK    (CLK),
        .RST    (RST),
        .i_load (w_load),
        .i_dec  (w_dec),
        .o_zero (w_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_lvl   <= '0;
            r_tgt   <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE, HOLD: begin
                    if (w_tgt_eff != r_lvl) begin
                        r_tgt <= w_tgt_eff;
                        if (w_tgt_eff > r_lvl) begin
                            r_lvl   <= r_lvl + 1'b1;
                            r_state <= RAMP_UP;
                            r_ack   <= 1'b0;
                            r_busy  <= 1'b1;
                        end else begin
`ifdef GF180MCU_OSU_DRV_SOFTOFF_EN
                            r_lvl   <= r_lvl - 1'b1;
                            r_state <= RAMP_DOWN;
                            r_ack   <= 1'b0;
                            r_busy  <= 1'b1;
`else
                            // Hard release: drop straight to target.
                            r_lvl   <= w_tgt_eff;
                            r_state <= (w_tgt_eff == '0) ? IDLE : HOLD;
                            r_ack   <= (w_tgt_eff != '0);
                            r_busy  <= 1'b0;
`endif
                        end
                    end
                end
                RAMP_UP, RAMP_DOWN: begin
                    if (w_zero) begin
                        if (r_lvl != r_tgt) begin
                            r_lvl <= (r_state == RAMP_UP) ? r_lvl + 1'b1
                                                          : r_lvl - 1'b1;
                        end else begin
                            r_state <= (r_lvl == '0) ? IDLE : HOLD;
                            r_ack   <= (r_lvl != '0);
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        STAGE_EN = '0;
        for (int i = 0; i < N_STAGES; i++) begin
            STAGE_EN[i] = therm_bit(32'(r_lvl), i);
        end
    end

    assign ACK  = r_ack;
    assign BUSY = r_busy;

endmodule
